// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//    Turns one valid/ready command into an APB3 SETUP/ACCESS transfer toward
//    a single completer. The result comes back on a valid/ready response
//    channel. A bounded ACCESS-phase timeout stops a stuck completer from
//    hanging the requester. Only one transfer is outstanding at a time.
//
// Ports
//    PCLK, PRESETn         clock (rising edge), async active-low reset
//    cmd_valid/cmd_ready   command handshake; cmd_ready = FSM idle
//    cmd_write/addr/wdata  command fields, sampled on acceptance only
//    rsp_valid/rsp_ready   response handshake
//    rsp_rdata             read data (0 for writes and timeouts)
//    rsp_err/rsp_timeout   PSLVERR seen or timeout / aborted by timeout
//    PSEL..PWDATA          APB requester outputs (registered)
//    PRDATA/PREADY/PSLVERR APB completer inputs
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL=1 PENABLE=0 for exactly one cycle
// ACCESS | PSEL=PENABLE=1, waiting for PREADY or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_cmd_master #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   // Counter holds 0..TIMEOUT_CYCLES-1; at least one bit even when disabled.
   localparam int CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TC_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] TC_LAST = CW'(TC_LAST_I);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic                  r_psel, w_psel_nxt;
   logic                  r_penable, w_penable_nxt;
   logic                  r_pwrite, w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
   logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
   logic                  r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic                  r_rsp_err, w_rsp_err_nxt;
   logic                  r_rsp_timeout, w_rsp_timeout_nxt;
   logic                  w_accept;
   logic                  w_timeout_hit;

   assign cmd_ready     = (r_state == ST_IDLE);
   assign w_accept      = cmd_valid & cmd_ready;
   // Last allowed ACCESS cycle; PREADY in this same cycle still completes normally.
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TC_LAST);

   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
         ST_SETUP:  w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (PREADY || w_timeout_hit) w_state_nxt = ST_RESP;
         ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; everything holds by default so
   // the APB address/data fields keep their last values between transfers.
   always_comb begin
      w_cnt_nxt         = r_cnt;
      w_psel_nxt        = r_psel;
      w_penable_nxt     = r_penable;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_rsp_timeout_nxt = r_rsp_timeout;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_pwrite_nxt  = cmd_write;
               w_paddr_nxt   = cmd_addr;
               w_pwdata_nxt  = cmd_wdata;
            end
         end
         ST_SETUP: begin
            w_penable_nxt = 1'b1;
            w_cnt_nxt     = '0;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
               w_rsp_err_nxt     = PSLVERR;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
            end else if (w_timeout_hit) begin
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_rsp_rdata_nxt   = '0;
               w_rsp_err_nxt     = 1'b1;
               w_rsp_timeout_nxt = 1'b1;
               w_rsp_valid_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) w_rsp_valid_nxt = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wd;
      int          waits;   // ACCESS cycles with PREADY low before PREADY high
      logic [31:0] rd;
      bit          slverr;
      int          hold;    // cycles rsp_ready stays low
      bit          b2b;     // next command presented while response pending
   } cmd_t;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, rsp_timeout;
   logic          PSEL, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic          PREADY, PSLVERR;

   int n_checks = 0;
   int n_errors = 0;
   cmd_t cmds[$];

   apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic junk_cmd();
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
   endtask

   task automatic drive_cmd(input cmd_t c);
      cmd_valid = 1'b1;
      cmd_write = c.wr;
      cmd_addr  = c.addr;
      cmd_wdata = c.wd;
   endtask

   // One complete transfer; called at a negedge with the DUT idle.
   // Returns at the negedge after the response handshake.
   task automatic xfer(input cmd_t c, input cmd_t nx);
      bit          exp_to;
      int          exp_cycles, k;
      logic [31:0] exp_rd;
      bit          exp_err, done;

      // Reference: timeout fires once the completer would need TO or more waits.
      exp_to     = (TO != 0) && (c.waits >= TO);
      exp_cycles = exp_to ? TO : c.waits + 1;
      exp_rd     = (c.wr || exp_to) ? 32'h0 : c.rd;
      exp_err    = exp_to ? 1'b1 : c.slverr;

      drive_cmd(c);
      chk("cmd_ready_idle", cmd_ready, 1);
      chk("psel_idle", PSEL, 0);
      cyc();
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_cmd_ready", cmd_ready, 0);
      chk("setup_paddr", PADDR, c.addr);
      chk("setup_pwrite", PWRITE, c.wr);
      chk("setup_pwdata", PWDATA, c.wd);
      junk_cmd();
      rsp_ready = 1'($urandom);
      PREADY    = 1'($urandom);
      PRDATA    = $urandom;
      PSLVERR   = 1'($urandom);
      cyc();
      chk("access_penable", PENABLE, 1);
      k    = 0;
      done = 0;
      while (!done) begin
         junk_cmd();
         PREADY  = (k == c.waits);
         PRDATA  = (k == c.waits) ? c.rd : $urandom;
         PSLVERR = (k == c.waits) ? c.slverr : 1'($urandom);
         cyc();
         if (rsp_valid) begin
            done = 1;
         end else begin
            chk("access_psel", PSEL, 1);
            chk("access_penable_hold", PENABLE, 1);
            chk("access_paddr", PADDR, c.addr);
            chk("access_pwdata", PWDATA, c.wd);
            k++;
            if (k > 40) begin
               chk("access_bound", k, exp_cycles);
               done = 1;
            end
         end
      end
      chk("access_cycles", k + 1, exp_cycles);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_timeout", rsp_timeout, exp_to);
      chk("resp_psel", {PSEL, PENABLE}, 2'b00);
      chk("resp_paddr_kept", PADDR, c.addr);
      PREADY = 1'($urandom);
      for (int h = 0; h < c.hold; h++) begin
         rsp_ready = 1'b0;
         if (c.b2b) drive_cmd(nx);
         else junk_cmd();
         cyc();
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_err", {rsp_err, rsp_timeout}, {exp_err, exp_to});
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_psel", PSEL, 0);
      end
      rsp_ready = 1'b1;
      if (c.b2b) drive_cmd(nx);
      else junk_cmd();
      cyc();
      chk("hs_valid_low", rsp_valid, 0);
      chk("hs_cmd_ready", cmd_ready, 1);
      chk("hs_psel", PSEL, 0);
      rsp_ready = 1'b0;
      if (!c.b2b) cmd_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t c, nx;
      PRESETn = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
      #12;
      chk("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
      chk("rst_rdata", rsp_rdata, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      cyc();
      chk("rst_cmd_ready", cmd_ready, 1);

      // wr, addr, wdata, waits, rdata, slverr, hold, b2b
      cmds.push_back('{1, 16'h0010, 32'hDEADBEEF, 0, 32'h1111_2222, 0, 0, 0});
      cmds.push_back('{0, 16'h0020, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0});
      cmds.push_back('{1, 16'h0030, 32'h5555AAAA, 0, 32'h0, 1, 0, 0});
      cmds.push_back('{1, 16'h0034, 32'h0BADF00D, 3, 32'h0, 0, 0, 0});
      cmds.push_back('{0, 16'h0040, 32'h0, 30, 32'h12345678, 0, 1, 0});
      cmds.push_back('{0, 16'h0044, 32'h0, 15, 32'h87654321, 0, 0, 0});
      cmds.push_back('{1, 16'h0050, 32'hA5A5A5A5, 2, 32'h0, 0, 5, 1});
      cmds.push_back('{0, 16'h0054, 32'h0, 0, 32'h600DD00D, 1, 0, 0});
      for (int i = 0; i < 30; i++) begin
         c.wr     = 1'($urandom);
         c.addr   = 16'($urandom);
         c.wd     = $urandom;
         c.waits  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
         c.rd     = $urandom;
         c.slverr = ($urandom_range(0, 3) == 0);
         c.hold   = int'($urandom_range(0, 4));
         c.b2b    = (i != 29) && 1'($urandom);
         cmds.push_back(c);
      end

      for (int i = 0; i < cmds.size(); i++) begin
         nx = (i + 1 < cmds.size()) ? cmds[i+1] : cmds[i];
         xfer(cmds[i], nx);
         if (!cmds[i].b2b) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               cyc();
               chk("gap_psel", PSEL, 0);
               chk("gap_rsp_valid", rsp_valid, 0);
            end
         end
      end

      // Reset in the middle of an ACCESS wait state
      c = '{1, 16'h1234, 32'hFEEDFACE, 50, 32'h0, 0, 0, 0};
      drive_cmd(c);
      PREADY = 1'b0;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      cyc();
      chk("mid_access", {PSEL, PENABLE}, 2'b11);
      #3 PRESETn = 1'b0;
      PREADY = 1'b1;
      #1;
      chk("mid_rst_apb", {PSEL, PENABLE}, 2'b00);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_paddr", PADDR, 0);
      chk("mid_rst_pwdata", PWDATA, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      chk("post_rst_cmd_ready", cmd_ready, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("post_rst_no_rsp", rsp_valid, 0);
         chk("post_rst_psel", PSEL, 0);
      end
      c = '{0, 16'h00F0, 32'h0, 2, 32'h0F0F0F0F, 0, 1, 0};
      xfer(c, c);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
